// File: rtl/barrier_wishbone_retry.sv
// ---------------------------------------------------------------------------
// barrier_wishbone_retry
//
// Registered Wishbone barrier between one upstream master and one downstream
// slave. The request is latched on the way down and the response is latched
// on the way up, so no combinational path crosses the block in either
// direction. A downstream RTY is absorbed and the request re-issued, after a
// one-cycle backoff, up to RETRY_LIMIT times. After that, RTY is returned
// upstream.
//
// Optional feature (compile-time macro WB_BARRIER_TIMEOUT_EN):
//   A watchdog counts ISSUE cycles. After TIMEOUT_CYCLES cycles with no
//   ACK/RTY it drops the downstream cycle and answers RTY upstream. That
//   final RTY counts as the last retry. When the macro is undefined the
//   watchdog is absent and ISSUE waits indefinitely.
//
// Ports
//   clk, rst                 clock (rising edge); asynchronous active-high reset
//   in_CYC/in_STB/in_WE      upstream request controls
//   in_SEL/in_ADR/in_DAT_M   upstream byte selects, address, write data
//   in_DAT_S                 read data to upstream, valid with in_ACK
//   in_ACK/in_RTY            one-cycle response pulses to upstream
//   out_CYC/out_STB/out_WE   downstream request controls
//   out_SEL/out_ADR/out_DAT_M latched request fields to downstream
//   out_DAT_S                downstream read data
//   out_ACK/out_RTY          downstream responses
// ---------------------------------------------------------------------------
module barrier_wishbone_retry #(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int RETRY_LIMIT    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_CYC,
    input  logic                  in_STB,
    input  logic                  in_WE,
    input  logic [SEL_WIDTH-1:0]  in_SEL,
    input  logic [ADDR_WIDTH-1:0] in_ADR,
    input  logic [DATA_WIDTH-1:0] in_DAT_M,
    output logic [DATA_WIDTH-1:0] in_DAT_S,
    output logic                  in_ACK,
    output logic                  in_RTY,
    output logic                  out_CYC,
    output logic                  out_STB,
    output logic                  out_WE,
    output logic [SEL_WIDTH-1:0]  out_SEL,
    output logic [ADDR_WIDTH-1:0] out_ADR,
    output logic [DATA_WIDTH-1:0] out_DAT_M,
    input  logic [DATA_WIDTH-1:0] out_DAT_S,
    input  logic                  out_ACK,
    input  logic                  out_RTY
);

    localparam int RC_W = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(RETRY_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_BACKOFF = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t          state;
    logic [RC_W-1:0] retry_cnt;

`ifdef WB_BARRIER_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt;
`else
    // Watchdog compiled out: TIMEOUT_CYCLES has no effect in this build.
    if (TIMEOUT_CYCLES < 0) begin : g_no_watchdog
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            retry_cnt <= '0;
            in_DAT_S  <= '0;
            in_ACK    <= 1'b0;
            in_RTY    <= 1'b0;
            out_CYC   <= 1'b0;
            out_STB   <= 1'b0;
            out_WE    <= 1'b0;
            out_SEL   <= '0;
            out_ADR   <= '0;
            out_DAT_M <= '0;
`ifdef WB_BARRIER_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
        end else begin
            // Response outputs are single-cycle pulses unless set below.
            in_ACK <= 1'b0;
            in_RTY <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_CYC && in_STB) begin
                        out_WE    <= in_WE;
                        out_SEL   <= in_SEL;
                        out_ADR   <= in_ADR;
                        out_DAT_M <= in_DAT_M;
                        out_CYC   <= 1'b1;
                        out_STB   <= 1'b1;
                        retry_cnt <= '0;
                        state     <= S_ISSUE;
`ifdef WB_BARRIER_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    // Upstream abort has priority, so a late downstream ACK
                    // is never forwarded to a master that has gone away.
                    if (!in_CYC) begin
                        out_CYC <= 1'b0;
                        out_STB <= 1'b0;
                        state   <= S_IDLE;
                    end else if (out_ACK) begin
                        // ACK wins over a simultaneous RTY.
                        in_DAT_S <= out_DAT_S;
                        in_ACK   <= 1'b1;
                        out_CYC  <= 1'b0;
                        out_STB  <= 1'b0;
                        state    <= S_RESP;
                    end else if (out_RTY) begin
                        out_CYC <= 1'b0;
                        out_STB <= 1'b0;
                        if (retry_cnt < RC_MAX) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= S_BACKOFF;
                        end else begin
                            in_RTY <= 1'b1;
                            state  <= S_RESP;
                        end
`ifdef WB_BARRIER_TIMEOUT_EN
                    end else if (wd_cnt == WD_LAST) begin
                        out_CYC   <= 1'b0;
                        out_STB   <= 1'b0;
                        in_RTY    <= 1'b1;
                        retry_cnt <= RC_MAX;
                        state     <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                S_BACKOFF: begin
                    // Request fields are untouched, so the re-issue is identical.
                    if (!in_CYC) begin
                        state <= S_IDLE;
                    end else begin
                        out_CYC <= 1'b1;
                        out_STB <= 1'b1;
                        state   <= S_ISSUE;
`ifdef WB_BARRIER_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                    end
                end
                default: begin
                    // S_RESP: the pulse is already on the outputs. in_STB is
                    // ignored here so a held strobe cannot start a new transaction.
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrier_wishbone_retry.sv
module tb_barrier_wishbone_retry;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int SW = 16;
    localparam int RL = 2;
    localparam int TO = 8;
    localparam int N  = 2048;

    localparam int K_ACK    = 0;
    localparam int K_RTY    = 1;
    localparam int K_BOTH   = 2;
    localparam int K_ABORT  = 3;
    localparam int K_SILENT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_CYC, in_STB, in_WE;
    logic [SW-1:0] in_SEL;
    logic [AW-1:0] in_ADR;
    logic [DW-1:0] in_DAT_M, in_DAT_S;
    logic          in_ACK, in_RTY;
    logic          out_CYC, out_STB, out_WE;
    logic [SW-1:0] out_SEL;
    logic [AW-1:0] out_ADR;
    logic [DW-1:0] out_DAT_M, out_DAT_S;
    logic          out_ACK, out_RTY;

    always #5 clk = ~clk;

    barrier_wishbone_retry #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW),
        .RETRY_LIMIT(RL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_CYC(in_CYC), .in_STB(in_STB), .in_WE(in_WE), .in_SEL(in_SEL),
        .in_ADR(in_ADR), .in_DAT_M(in_DAT_M), .in_DAT_S(in_DAT_S),
        .in_ACK(in_ACK), .in_RTY(in_RTY),
        .out_CYC(out_CYC), .out_STB(out_STB), .out_WE(out_WE), .out_SEL(out_SEL),
        .out_ADR(out_ADR), .out_DAT_M(out_DAT_M), .out_DAT_S(out_DAT_S),
        .out_ACK(out_ACK), .out_RTY(out_RTY)
    );

    // Cycle index: number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle behaviour and scheduled slave responses.
    bit e_cyc [N];
    bit e_ack [N];
    bit e_rty [N];
    bit s_ack [N];
    bit s_rty [N];
    logic          e_we;
    logic [SW-1:0] e_sel;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_datm, e_dat;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int n_ack, n_rty, n_rise, n_hi, ack_at, last_m;
    bit prev_cyc = 1'b0;
    int pw [4];
    int pk [4];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clr_mon();
        n_ack = 0; n_rty = 0; n_rise = 0; n_hi = 0; ack_at = -1;
    endtask

    // Per-cycle compare against the model, plus event monitors.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("out_CYC", DW'(out_CYC), DW'(e_cyc[cyc]));
            chk("out_STB", DW'(out_STB), DW'(e_cyc[cyc]));
            chk("in_ACK",  DW'(in_ACK),  DW'(e_ack[cyc]));
            chk("in_RTY",  DW'(in_RTY),  DW'(e_rty[cyc]));
            if (e_cyc[cyc]) begin
                chk("out_WE",    DW'(out_WE),  DW'(e_we));
                chk("out_SEL",   DW'(out_SEL), DW'(e_sel));
                chk("out_ADR",   DW'(out_ADR), DW'(e_adr));
                chk("out_DAT_M", out_DAT_M,    e_datm);
            end
            if (e_ack[cyc]) chk("in_DAT_S", in_DAT_S, e_dat);
        end
        if (!rst) begin
            if (in_ACK) begin n_ack++; ack_at = cyc; end
            if (in_RTY) n_rty++;
            if (out_CYC) n_hi++;
            if (out_CYC && !prev_cyc) n_rise++;
            prev_cyc = out_CYC;
        end
    end

    // Plan one transaction from its slave script, then drive it.
    task automatic run(input logic we, input logic [SW-1:0] sel, input logic [AW-1:0] adr,
                       input logic [DW-1:0] datm, input logic [DW-1:0] rdat, input int na);
        int m, t, cnt, drop, fin, w, k;
        bit done;
        @(negedge clk);
        m = cyc; last_m = m;
        e_we = we; e_sel = sel; e_adr = adr; e_datm = datm; e_dat = rdat;
        t = m + 1; cnt = 0; done = 1'b0; drop = m;
        for (int i = 0; i < na && !done; i++) begin
            w = pw[i]; k = pk[i];
            if (k == K_SILENT) begin
                for (int c = t; c < t + TO; c++) e_cyc[c] = 1'b1;
                e_rty[t+TO] = 1'b1; drop = t + TO; done = 1'b1;
            end else begin
                for (int c = t; c <= t + w; c++) e_cyc[c] = 1'b1;
                if (k == K_ABORT) begin
                    drop = t + w; s_ack[t+w+1] = 1'b1; done = 1'b1;
                end else begin
                    s_ack[t+w] = (k != K_RTY);
                    s_rty[t+w] = (k != K_ACK);
                    if (k != K_RTY) begin
                        e_ack[t+w+1] = 1'b1; drop = t + w + 1; done = 1'b1;
                    end else if (cnt < RL) begin
                        cnt++; t = t + w + 2;
                    end else begin
                        e_rty[t+w+1] = 1'b1; drop = t + w + 1; done = 1'b1;
                    end
                end
            end
        end
        fin = drop + 3;
        while (cyc <= fin) begin
            if (cyc == m) begin
                in_CYC = 1'b1; in_STB = 1'b1; in_WE = we;
                in_SEL = sel; in_ADR = adr; in_DAT_M = datm;
            end
            if (cyc == drop) begin in_CYC = 1'b0; in_STB = 1'b0; end
            out_ACK   = s_ack[cyc];
            out_RTY   = s_rty[cyc];
            out_DAT_S = s_ack[cyc] ? rdat : ~rdat;
            @(negedge clk);
        end
        out_ACK = 1'b0; out_RTY = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_CYC = 0; in_STB = 0; in_WE = 0; in_SEL = '0; in_ADR = '0; in_DAT_M = '0;
        out_DAT_S = '0; out_ACK = 0; out_RTY = 0;
        clr_mon();
        repeat (3) @(negedge clk);
        chk("reset out_CYC",   DW'(out_CYC), '0);
        chk("reset out_STB",   DW'(out_STB), '0);
        chk("reset in_ACK",    DW'(in_ACK),  '0);
        chk("reset in_RTY",    DW'(in_RTY),  '0);
        chk("reset out_ADR",   DW'(out_ADR), '0);
        chk("reset out_DAT_M", out_DAT_M,    '0);
        chk("reset in_DAT_S",  in_DAT_S,     '0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Reset while a request is outstanding downstream.
        chk_en = 1'b0;
        in_CYC = 1; in_STB = 1; in_WE = 1; in_SEL = 16'hFFFF;
        in_ADR = 32'h0000_0BAD; in_DAT_M = {4{32'hA5A5_5A5A}};
        @(negedge clk);
        chk("t1 out_CYC before rst", DW'(out_CYC), DW'(1));
        #2 rst = 1'b1;
        #1;
        chk("t1 async out_CYC", DW'(out_CYC), '0);
        chk("t1 async out_STB", DW'(out_STB), '0);
        chk("t1 async out_WE",  DW'(out_WE),  '0);
        chk("t1 async out_ADR", DW'(out_ADR), '0);
        @(negedge clk);
        in_CYC = 0; in_STB = 0;
        @(negedge clk);
        rst = 1'b0;
        clr_mon();
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1 no in_ACK", DW'(n_ack), '0);

        // Read, slave answers 3 cycles after out_STB.
        clr_mon(); pw = '{3, 0, 0, 0}; pk = '{K_ACK, 0, 0, 0};
        run(1'b0, 16'hFFFF, 32'h0000_1000, '0, {4{32'hDEAD_BEEF}}, 1);
        chk("t2 ack count",   DW'(n_ack), DW'(1));
        chk("t2 ack latency", DW'(ack_at - last_m), DW'(5));

        // Zero-wait slave.
        clr_mon(); pw = '{0, 0, 0, 0}; pk = '{K_ACK, 0, 0, 0};
        run(1'b0, 16'h0F0F, 32'h0000_1010, '0, {4{32'h0BAD_F00D}}, 1);
        chk("zero-wait latency", DW'(ack_at - last_m), DW'(2));

        // Write, fields must pass bit-exact.
        clr_mon(); pw = '{1, 0, 0, 0}; pk = '{K_ACK, 0, 0, 0};
        run(1'b1, 16'h00F0, 32'h0000_2040, {4{32'h1234_5678}}, {4{32'h0000_0042}}, 1);
        chk("t3 ack count", DW'(n_ack), DW'(1));

        // RTY, RTY, ACK: two gaps, absorbed.
        clr_mon(); pw = '{1, 0, 2, 0}; pk = '{K_RTY, K_RTY, K_ACK, 0};
        run(1'b0, 16'hFFFF, 32'h0000_3000, '0, {4{32'hCAFE_0001}}, 3);
        chk("t4a ack count", DW'(n_ack),  DW'(1));
        chk("t4a rty count", DW'(n_rty),  '0);
        chk("t4a issues",    DW'(n_rise), DW'(3));

        // RTY x3: limit exceeded, one upstream RTY.
        clr_mon(); pw = '{0, 1, 0, 0}; pk = '{K_RTY, K_RTY, K_RTY, 0};
        run(1'b1, 16'h0001, 32'h0000_3010, {4{32'h7777_0000}}, '0, 3);
        chk("t4b rty count", DW'(n_rty),  DW'(1));
        chk("t4b ack count", DW'(n_ack),  '0);
        chk("t4b issues",    DW'(n_rise), DW'(3));

        // ACK and RTY together: ACK wins.
        clr_mon(); pw = '{1, 2, 0, 0}; pk = '{K_RTY, K_BOTH, 0, 0};
        run(1'b0, 16'hFFFF, 32'h0000_4000, '0, {4{32'h5555_AAAA}}, 2);
        chk("t5 ack count", DW'(n_ack), DW'(1));
        chk("t5 rty count", DW'(n_rty), '0);

        // Upstream abort, late downstream ACK ignored.
        clr_mon(); pw = '{2, 0, 0, 0}; pk = '{K_ABORT, 0, 0, 0};
        run(1'b0, 16'hFFFF, 32'h0000_5000, '0, {4{32'h1111_2222}}, 1);
        chk("abort ack count", DW'(n_ack), '0);
        chk("abort rty count", DW'(n_rty), '0);

        // Silent slave.
        clr_mon();
`ifdef WB_BARRIER_TIMEOUT_EN
        pw = '{0, 0, 0, 0}; pk = '{K_SILENT, 0, 0, 0};
        run(1'b0, 16'hFFFF, 32'h0000_6000, '0, '0, 1);
        chk("t6 out_CYC high cycles", DW'(n_hi), DW'(TO));
        chk("t6 rty count", DW'(n_rty), DW'(1));
`else
        pw = '{110, 0, 0, 0}; pk = '{K_ABORT, 0, 0, 0};
        run(1'b0, 16'hFFFF, 32'h0000_6000, '0, '0, 1);
        chk("t6 out_CYC high cycles", DW'(n_hi), DW'(111));
        chk("t6 rty count", DW'(n_rty), '0);
`endif
        chk("t6 ack count", DW'(n_ack), '0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global time limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

endmodule
